// File: rtl/alu_share_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_pkg
// Purpose  : Shared types, default widths and round-robin pick helper for
//            the ALU sharing scheduler.
// Revision : 1.0
// ============================================================================
package alu_share_pkg;

    localparam int ALU_IN_W  = 60;
    localparam int ALU_OUT_W = 26;
    localparam int c_RR_MAX  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // One-hot winner: first set bit of valid scanning ptr, ptr+1, ... mod num.
    function automatic logic [c_RR_MAX-1:0] rr_pick(
        input logic [c_RR_MAX-1:0] valid,
        input logic [2:0]          ptr,
        input int                  num
    );
        logic [c_RR_MAX-1:0] pick;
        int                  idx;
        pick = '0;
        for (int k = 0; k < c_RR_MAX; k++) begin
            idx = int'(ptr) + k;
            if (idx >= num) idx = idx - num;
            if (k < num && pick == '0 && idx < c_RR_MAX && valid[idx[2:0]])
                pick[idx[2:0]] = 1'b1;
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin winner select plus the priority
//            pointer register with its advance enable.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               start_en,
    input  logic [PTR_W-1:0]   start_ptr,
    input  logic               adv_en,
    input  logic [PTR_W-1:0]   adv_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    w_start;
    logic [c_RR_MAX-1:0] w_valid_ext;
    logic [c_RR_MAX-1:0] w_pick;
    logic                w_unused;

    // start_en lets the caller scan from a point other than the stored pointer
    assign w_start     = start_en ? start_ptr : r_ptr;
    assign w_valid_ext = c_RR_MAX'(valid);
    assign w_pick      = rr_pick(w_valid_ext, 3'(w_start), NUM_REQ);
    assign grant       = w_pick[NUM_REQ-1:0];
    assign w_unused    = ^w_pick;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (adv_en) begin
            r_ptr <= adv_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_sched
// Purpose  : Round-robin time-multiplexing of one combinational ALU slice
//            with a programmable settle window. ALU_SHARE_LOCK_EN adds the
//            per-requester grant hold (lock port).
// Revision : 1.0
// ============================================================================
module alu_share_sched
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = ALU_IN_W,
    parameter int OUT_W   = ALU_OUT_W,
    parameter int SETTLE  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [OUT_W-1:0]        resp_data,
    output logic [IN_W-1:0]         alu_in,
    input  logic [OUT_W-1:0]        alu_out,
    output logic                    busy
`ifdef ALU_SHARE_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]      lock
`endif
);

    localparam int         c_PTR_W    = $clog2(NUM_REQ);
    localparam logic [3:0] c_CNT_INIT = 4'(SETTLE - 1);

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_owner;
    logic [3:0]           r_cnt;
    logic [NUM_REQ-1:0]   r_resp_valid;
    logic [OUT_W-1:0]     r_resp_data;
    logic [IN_W-1:0]      r_alu_in;
    logic                 r_busy;
    logic                 r_reserved;

    logic [NUM_REQ-1:0]   w_lock;
    logic [NUM_REQ-1:0]   w_owner_oh;
    logic [NUM_REQ-1:0]   w_arb_valid;
    logic [NUM_REQ-1:0]   w_grant;
    logic [c_PTR_W-1:0]   w_grant_idx;
    logic [c_PTR_W-1:0]   w_owner_next;
    logic [IN_W-1:0]      w_sel_data;
    logic                 w_idle;
    logic                 w_hold;
    logic                 w_release;
    logic                 w_done;
    logic                 w_adv;

`ifdef ALU_SHARE_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = '0;
`endif

    assign w_idle       = (r_state == ST_IDLE);
    assign w_owner_oh   = NUM_REQ'(1) << r_owner;
    assign w_owner_next = (r_owner == c_PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_hold       = w_idle && r_reserved && w_lock[r_owner];
    assign w_release    = w_idle && r_reserved && !w_lock[r_owner];
    assign w_done       = (r_state == ST_RESP) && resp_ready[r_owner];
    // A released reservation completes the pointer advance that the lock deferred
    assign w_adv        = (w_done && !w_lock[r_owner]) || w_release;
    assign w_arb_valid  = !w_idle ? '0 : (w_hold ? (req_valid & w_owner_oh) : req_valid);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (w_arb_valid),
        .start_en  (w_release),
        .start_ptr (w_owner_next),
        .adv_en    (w_adv),
        .adv_ptr   (w_owner_next),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) w_sel_data = req_data[i*IN_W +: IN_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_cnt        <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_alu_in     <= '0;
            r_busy       <= 1'b0;
            r_reserved   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_alu_in   <= w_sel_data;
                        r_owner    <= w_grant_idx;
                        r_cnt      <= c_CNT_INIT;
                        r_busy     <= 1'b1;
                        r_reserved <= 1'b0;
                        r_state    <= ST_SETTLE;
                    end else if (w_release) begin
                        r_reserved <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_resp_data  <= alu_out;
                        r_resp_valid <= w_owner_oh;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (w_done) begin
                        r_resp_valid <= '0;
                        r_busy       <= 1'b0;
                        r_reserved   <= w_lock[r_owner];
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_grant;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign alu_in     = r_alu_in;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_sched
// Purpose  : Self-checking bench for alu_share_sched (vector table, directed
//            corner sequences, randomized traffic against a reference model).
// Revision : 1.0
// ============================================================================
module tb_alu_share_sched;

    localparam int N  = 4;
    localparam int IW = 60;
    localparam int OW = 26;
    localparam int ST = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [N*IW-1:0] req_data;
    logic [OW-1:0]   resp_data, alu_out;
    logic [IW-1:0]   alu_in;
    logic            busy;
`ifdef ALU_SHARE_LOCK_EN
    logic [N-1:0]    lock;
`endif

    logic [IW-1:0]   dat [N];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;

    logic [N-1:0]    s_rdy, s_rv;
    logic [OW-1:0]   s_rd;
    logic [IW-1:0]   s_ai;
    logic            s_busy;

    // transaction-level reference state
    bit              m_busy;
    bit              m_res;
    int              m_owner, m_ptr, m_t0;
    logic [IW-1:0]   m_alu_in;
    logic [OW-1:0]   m_resp_data;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] rr;
        logic [N-1:0] rdy;
        logic [N-1:0] rv;
        logic         bsy;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] alu_f(input logic [IW-1:0] x);
        return (x[25:0] + x[51:26]) ^ {x[59:52], 18'd0};
    endfunction

    assign alu_out = alu_f(alu_in);

    alu_share_sched #(
        .NUM_REQ (N),
        .IN_W    (IW),
        .OUT_W   (OW),
        .SETTLE  (ST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_in     (alu_in),
        .alu_out    (alu_out),
        .busy       (busy)
`ifdef ALU_SHARE_LOCK_EN
        ,
        .lock       (lock)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int rr_model(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int oh2i(input logic [N-1:0] oh);
        for (int i = 0; i < N; i++) if (oh[i]) return i;
        return -1;
    endfunction

    // One clock: drive inputs, sample at negedge, check against model, advance.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] rr, input logic do_rst);
        int w, el;
        logic [N-1:0] e_rdy, e_rv;
        logic e_busy;
        req_valid  = v;
        resp_ready = rr;
        rst        = do_rst;
        for (int i = 0; i < N; i++) req_data[i*IW +: IW] = dat[i];
        @(negedge clk);
        s_rdy = req_ready; s_rv = resp_valid; s_rd = resp_data; s_ai = alu_in; s_busy = busy;
        if (!do_rst) begin
            e_rdy = '0; e_rv = '0; e_busy = 1'b0; w = -1; el = 0;
            if (!m_busy) begin
                w = rr_model(v, m_ptr);
`ifdef ALU_SHARE_LOCK_EN
                if (m_res && lock[m_owner]) begin
                    w = v[m_owner] ? m_owner : -1;
                end else if (m_res) begin
                    m_res = 0;
                    m_ptr = (m_owner + 1) % N;
                    w     = rr_model(v, m_ptr);
                end
`endif
                if (w >= 0) e_rdy[w] = 1'b1;
            end else begin
                e_busy = 1'b1;
                el = cyc - m_t0;
                if (el > ST) e_rv[m_owner] = 1'b1;
            end
            check("model_req_ready", s_rdy, e_rdy);
            check("model_resp_valid", s_rv, e_rv);
            check("model_busy", s_busy, e_busy);
            check("model_alu_in", s_ai, m_alu_in);
            check("model_resp_data", s_rd, m_resp_data);
            if (!m_busy) begin
                if (w >= 0) begin
                    m_busy = 1; m_owner = w; m_t0 = cyc; m_alu_in = dat[w]; m_res = 0;
                end
            end else begin
                if (el == ST) m_resp_data = alu_f(m_alu_in);
                if (el > ST && rr[m_owner]) begin
                    m_busy = 0;
`ifdef ALU_SHARE_LOCK_EN
                    if (lock[m_owner]) m_res = 1; else
`endif
                    m_ptr = (m_owner + 1) % N;
                end
            end
        end else begin
            m_busy = 0; m_res = 0; m_ptr = 0; m_owner = 0;
            m_alu_in = '0; m_resp_data = '0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int k;
        k = 0;
        do begin
            cycle('0, '1, 1'b0);
            k++;
        end while (s_busy && k < 20);
        check("drain_idle", s_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gidx[$];
        int gcyc[$];
        int exp_order[5];
        logic [N-1:0] pend;
        logic [OW-1:0] held;
        logic do_r;

        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req_valid = '0; resp_ready = '0; req_data = '0;
`ifdef ALU_SHARE_LOCK_EN
        lock = '0;
`endif
        for (int i = 0; i < N; i++) dat[i] = IW'(64'h0111_1111_1111_1111 * (i + 1));
        m_busy = 0; m_res = 0; m_ptr = 0; m_owner = 0; m_t0 = 0;
        m_alu_in = '0; m_resp_data = '0;
        @(posedge clk); #1;

        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b0);
        check("reset_req_ready", s_rdy, '0);
        check("reset_resp_valid", s_rv, '0);
        check("reset_busy", s_busy, 1'b0);
        check("reset_alu_in", s_ai, '0);
        check("reset_resp_data", s_rd, '0);

        // single request on requester 2
        dat[2] = 60'h0AB_CDEF_0123_4567;
        tbl[0] = '{4'b0100, 4'b1111, 4'b0100, 4'b0000, 1'b0};
        tbl[1] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1};
        tbl[2] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1};
        tbl[3] = '{4'b0000, 4'b1111, 4'b0000, 4'b0100, 1'b1};
        tbl[4] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0};
        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i].v, tbl[i].rr, 1'b0);
            check("tbl_req_ready", s_rdy, tbl[i].rdy);
            check("tbl_resp_valid", s_rv, tbl[i].rv);
            check("tbl_busy", s_busy, tbl[i].bsy);
            if (i == 1) check("tbl_alu_in", s_ai, dat[2]);
            if (i == 3) check("tbl_resp_data", s_rd, alu_f(dat[2]));
        end

        // all requesters continuously valid, from a fresh pointer
        cycle('0, '1, 1'b1);
        for (int k = 0; k < 17; k++) begin
            cycle('1, '1, 1'b0);
            if (s_rdy != '0) begin
                gidx.push_back(oh2i(s_rdy));
                gcyc.push_back(k);
            end
        end
        check("allreq_grant_count", gidx.size(), 5);
        for (int j = 0; j < gidx.size() && j < 5; j++) begin
            check("allreq_order", gidx[j], exp_order[j]);
            if (j > 0) check("allreq_interval", gcyc[j] - gcyc[j-1], ST + 2);
        end
        drain();

        // response backpressure on owner 1, non-owners ready
        dat[1] = 60'hF0F_0F0F_A5A5_5A5A;
        cycle(4'b0010, '0, 1'b0);
        check("bp_grant", s_rdy, 4'b0010);
        held = alu_f(dat[1]);
        for (int k = 0; k < 7; k++) begin
            cycle(4'b1101, 4'b1101, 1'b0);
            check("bp_no_ready", s_rdy, '0);
            if (k >= 2) begin
                check("bp_resp_valid", s_rv, 4'b0010);
                check("bp_resp_data", s_rd, held);
            end
        end
        cycle(4'b1101, 4'b0010, 1'b0);
        check("bp_handshake_valid", s_rv, 4'b0010);
        cycle(4'b1101, '1, 1'b0);
        check("bp_next_grant", s_rdy, 4'b0100);
        drain();

        // pointer wrap after owner 3
        cycle(4'b1000, '1, 1'b0);
        check("wrap_grant3", s_rdy, 4'b1000);
        for (int k = 0; k < ST + 1; k++) cycle(4'b1001, '1, 1'b0);
        cycle(4'b1001, '1, 1'b0);
        check("wrap_grant0", s_rdy, 4'b0001);
        drain();

        // reset in the settle window
        cycle(4'b0100, '1, 1'b0);
        check("rst_pre_grant", s_rdy, 4'b0100);
        cycle('0, '1, 1'b1);
        cycle('0, '1, 1'b0);
        check("rst_mid_busy", s_busy, 1'b0);
        check("rst_mid_alu_in", s_ai, '0);
        check("rst_mid_resp_data", s_rd, '0);
        for (int k = 0; k < 3; k++) begin
            cycle('0, '1, 1'b0);
            check("rst_no_resp", s_rv, '0);
        end
        cycle('1, '1, 1'b0);
        check("rst_next_grant", s_rdy, 4'b0001);
        drain();

`ifdef ALU_SHARE_LOCK_EN
        // grant hold on requester 1
        gidx.delete();
        lock = 4'b0010;
        for (int k = 0; k < 60 && gidx.size() < 4; k++) begin
            cycle(4'b0110, '1, 1'b0);
            if (s_rdy != '0) begin
                gidx.push_back(oh2i(s_rdy));
                if (gidx.size() == 3) lock = '0;
            end
        end
        check("lock_grant_count", gidx.size(), 4);
        for (int j = 0; j < gidx.size() && j < 4; j++)
            check("lock_order", gidx[j], (j < 3) ? 1 : 2);
        lock = '0;
        drain();
`endif

        // randomized traffic against the model
        pend = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    dat[i]  = {$urandom, $urandom} & {4'h0, {60{1'b1}}};
                end else if (pend[i] && $urandom_range(0, 31) == 0) begin
                    pend[i] = 1'b0;
                end
            end
`ifdef ALU_SHARE_LOCK_EN
            lock = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
`endif
            do_r = ($urandom_range(0, 199) == 0);
            cycle(pend, N'($urandom), do_r);
            if (!do_r) pend = pend & ~s_rdy;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
